// File: rtl/debounce_bus_multi_pkg.sv
// Shared definitions for the multi-channel bus debouncer: default sizes,
// a constant clog2 helper and a packed-bus channel slice macro.

`ifndef DEBOUNCE_DEFS_MACROS
`define DEBOUNCE_DEFS_MACROS
// Selects channel c of a bus packed as CHANNELS words of w bits each.
`define DEBOUNCE_SLICE(bus, c, w) bus[(c)*(w) +: (w)]
`endif

package debounce_defs;

  localparam int DEFAULT_WIDTH         = 24;
  localparam int DEFAULT_STABLE_CYCLES = 3;

  // Ceiling log2, never below 1 so derived counters always have a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_bus_multi_channel.sv
// One debouncer slice: tracks a candidate word, counts consecutive enabled
// samples that match it, and commits it to clean once the count is reached.

module debounce_channel
  import debounce_defs::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] noisy,
  output logic [WIDTH-1:0] clean,
  output logic             stable,
  output logic             updated
);

  localparam int CNT_W = clog2(STABLE_CYCLES + 1);
  // Count value at which the next matching sample commits; also the
  // saturation point so the counter never wraps while a value is held.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] count;

  // Candidate capture, stability count, commit and change strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      candidate <= '0;
      count     <= '0;
      clean     <= '0;
      stable    <= 1'b0;
      updated   <= 1'b0;
    end else if (enable) begin
      if (noisy != candidate) begin
        // Any difference in the full word restarts the count; clean keeps
        // the last committed value.
        candidate <= noisy;
        count     <= '0;
        stable    <= 1'b0;
        updated   <= 1'b0;
      end else if (count < LAST) begin
        count   <= count + 1'b1;
        updated <= 1'b0;
      end else begin
        // Re-committing an identical value keeps the strobe low, so it
        // marks real changes of clean only.
        clean   <= candidate;
        stable  <= 1'b1;
        count   <= LAST;
        updated <= (candidate != clean);
      end
    end else begin
      updated <= 1'b0;
    end
  end

endmodule

// File: rtl/debounce_bus_multi.sv
// Multi-channel bus debouncer: CHANNELS independent debounce slices sharing
// one clock, reset and sample enable, on packed input/output buses.

module debounce_bus_multi
  import debounce_defs::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] noisyIn,
  output logic [CHANNELS*WIDTH-1:0] cleanOut,
  output logic [CHANNELS-1:0]       stable,
  output logic [CHANNELS-1:0]       updated
);

  // A zero stability count would commit on the capture sample itself,
  // which the slice logic does not model.
  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("debounce_bus_multi: STABLE_CYCLES must be >= 1");
  end

  // One independent slice per channel.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    debounce_channel #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_channel (
      .clock   (clock),
      .reset   (reset),
      .enable  (enable),
      .noisy   (`DEBOUNCE_SLICE(noisyIn, c, WIDTH)),
      .clean   (`DEBOUNCE_SLICE(cleanOut, c, WIDTH)),
      .stable  (stable[c]),
      .updated (updated[c])
    );
  end

endmodule

// File: tb/tb_debounce_bus_multi.sv
// Directed bench for debounce_bus_multi with two 24-bit channels and a
// stability count of 3.

module tb_debounce_bus_multi;

  localparam int W  = 24;
  localparam int CH = 2;
  localparam int SC = 3;

  logic            clock;
  logic            reset;
  logic            enable;
  logic [CH*W-1:0] noisy_in;
  logic [CH*W-1:0] clean_out;
  logic [CH-1:0]   stable;
  logic [CH-1:0]   updated;

  int n_checks;
  int n_fail;

  debounce_bus_multi #(
    .WIDTH         (W),
    .CHANNELS      (CH),
    .STABLE_CYCLES (SC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .noisyIn  (noisy_in),
    .cleanOut (clean_out),
    .stable   (stable),
    .updated  (updated)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] v);
    noisy_in[c*W +: W] = v;
  endtask

  function automatic logic [W-1:0] clean_ch(input int c);
    return clean_out[c*W +: W];
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    enable   = 1'b1;
    noisy_in = '0;

    // Reset state
    tick();
    tick();
    check("rst_clean", 64'(clean_out), 64'h0);
    check("rst_stable", 64'(stable), 64'h0);
    check("rst_updated", 64'(updated), 64'h0);

    // Zero input after release: candidate already matches, so the third
    // released edge (fourth counting the reset edge) commits silently.
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_stable_early", 64'(stable), 64'h0);
    tick();
    check("post_rst_stable", 64'(stable), 64'h3);
    check("post_rst_updated", 64'(updated), 64'h0);

    // Clean step on ch0
    set_ch(0, 24'h00ABCD);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("step_clean0", 64'(clean_ch(0)), (i >= 4) ? 64'h00ABCD : 64'h0);
      check("step_upd", 64'(updated), (i == 4) ? 64'h1 : 64'h0);
      check("step_stable0", 64'(stable[0]), (i >= 4) ? 64'h1 : 64'h0);
      check("step_clean1", 64'(clean_ch(1)), 64'h0);
    end

    // Bounce on ch0, ending on 0x10 so the hold of 0x11 is a fresh value
    for (int i = 0; i < 10; i++) begin
      set_ch(0, (i % 2 == 0) ? 24'h000011 : 24'h000010);
      tick();
      check("bounce_stable0", 64'(stable[0]), 64'h0);
      check("bounce_clean0", 64'(clean_ch(0)), 64'h00ABCD);
      check("bounce_upd", 64'(updated), 64'h0);
    end
    set_ch(0, 24'h000011);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("hold_clean0", 64'(clean_ch(0)), (i == 4) ? 64'h000011 : 64'h00ABCD);
      check("hold_upd", 64'(updated), (i == 4) ? 64'h1 : 64'h0);
    end

    // Glitch on the commit sample
    set_ch(0, 24'h123456);
    for (int i = 0; i < 3; i++) tick();
    set_ch(0, 24'h123457);
    tick();
    check("glitch_clean0", 64'(clean_ch(0)), 64'h000011);
    check("glitch_stable0", 64'(stable[0]), 64'h0);
    check("glitch_upd", 64'(updated), 64'h0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("glitch_hold_clean0", 64'(clean_ch(0)), (i == 4) ? 64'h123457 : 64'h000011);
      check("glitch_hold_upd", 64'(updated), (i == 4) ? 64'h1 : 64'h0);
    end

    // Enable gating on ch1: enabled samples at i = 0, 3, 6, 9
    set_ch(1, 24'hFFFFFF);
    for (int i = 0; i < 12; i++) begin
      enable = (i % 3 == 0);
      tick();
      check("gate_clean1", 64'(clean_ch(1)), (i >= 9) ? 64'hFFFFFF : 64'h0);
      check("gate_upd", 64'(updated), (i == 9) ? 64'h2 : 64'h0);
      check("gate_clean0", 64'(clean_ch(0)), 64'h123457);
    end
    enable = 1'b1;

    // Same-value re-commit on ch0
    set_ch(0, 24'h000005);
    for (int i = 1; i <= 4; i++) tick();
    check("recommit_first_clean0", 64'(clean_ch(0)), 64'h000005);
    check("recommit_first_upd", 64'(updated), 64'h1);
    set_ch(0, 24'h000006);
    tick();
    check("dip_stable0", 64'(stable[0]), 64'h0);
    check("dip_clean0", 64'(clean_ch(0)), 64'h000005);
    check("dip_upd", 64'(updated), 64'h0);
    set_ch(0, 24'h000005);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("return_stable0", 64'(stable[0]), (i == 4) ? 64'h1 : 64'h0);
      check("return_clean0", 64'(clean_ch(0)), 64'h000005);
      check("return_upd", 64'(updated), 64'h0);
    end

    // Reset mid-operation: ch1 pulsing, ch0 two edges into its count
    set_ch(1, 24'h00AA55);
    tick();
    tick();
    set_ch(0, 24'h000777);
    tick();
    tick();
    check("pre_rst_upd", 64'(updated), 64'h2);
    reset = 1'b1;
    tick();
    check("mid_rst_clean", 64'(clean_out), 64'h0);
    check("mid_rst_stable", 64'(stable), 64'h0);
    check("mid_rst_upd", 64'(updated), 64'h0);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("restart_clean0", 64'(clean_ch(0)), (i >= 4) ? 64'h000777 : 64'h0);
      check("restart_clean1", 64'(clean_ch(1)), (i >= 4) ? 64'h00AA55 : 64'h0);
      check("restart_upd", 64'(updated), (i == 4) ? 64'h3 : 64'h0);
      check("restart_stable", 64'(stable), (i >= 4) ? 64'h3 : 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
